// File: rtl/ntt_pkg.sv
// Shared types and default geometry for the NTT row buffer.
package ntt_pkg;

    typedef enum logic [1:0] {StLoad, StIssue, StCapture, StDrain} state_e;

    localparam int unsigned DefLanes = 8;
    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefDepth = 8;
    // Width of one packed row, lane 0 in the LSBs.
    localparam int unsigned DefRowW  = DefLanes * DefWidth;

endpackage

// File: rtl/ntt_row_buffer_if.sv
// Row traffic of the NTT row buffer: load, issue, result capture and readout.
interface ntt_row_buffer_if import ntt_pkg::*; #(
    parameter int unsigned LANES = DefLanes,
    parameter int unsigned WIDTH = DefWidth
);
    localparam int unsigned ROW_W = LANES * WIDTH;

    logic             wr_valid;
    logic             wr_ready;
    logic [ROW_W-1:0] wr_data;
    logic             iss_valid;
    logic             iss_ready;
    logic [ROW_W-1:0] iss_data;
    logic             res_valid;
    logic [ROW_W-1:0] res_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [ROW_W-1:0] rd_data;

    // master is the surrounding system (row source, NTT engine, row sink).
    modport master (
        output wr_valid, wr_data, iss_ready, res_valid, res_data, rd_ready,
        input  wr_ready, iss_valid, iss_data, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, iss_ready, res_valid, res_data, rd_ready,
        output wr_ready, iss_valid, iss_data, rd_valid, rd_data
    );

endinterface

// File: rtl/ntt_row_bank.sv
// Row storage: one synchronous write port, one combinational read port.
module ntt_row_bank import ntt_pkg::*; #(
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned ROW_W = DefRowW
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [ROW_W-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [ROW_W-1:0]         rdata
);

    logic [ROW_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ntt_row_buffer.sv
// Block buffer between a row source, an NTT engine and a row sink.
// Optional twiddle table enabled by NTT_ROW_BUFFER_TWIDDLE_EN.
module ntt_row_buffer import ntt_pkg::*; #(
    parameter int unsigned LANES = DefLanes,
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth
) (
    input  logic                           clk,
    input  logic                           rst,
    ntt_row_buffer_if.slave                bus,
    output logic                           busy,
    output logic                           ovf_err,
    input  logic                           tw_we,
    input  logic [$clog2(DEPTH*LANES)-1:0] tw_addr,
    input  logic [WIDTH-1:0]               tw_wdata,
    input  logic [$clog2(DEPTH*LANES)-1:0] tw_raddr,
    output logic [WIDTH-1:0]               tw_rdata
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned ROW_W = LANES * WIDTH;
    localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);

    state_e        state_q;
    logic [PW-1:0] wr_ptr_q, iss_ptr_q, cap_ptr_q, rd_ptr_q;
    logic          wr_ready_q, iss_valid_q, rd_valid_q, busy_q, ovf_q;

    logic wr_fire, iss_fire, rd_fire, cap_ok, res_drop;

    always_comb begin
        wr_fire  = bus.wr_valid & wr_ready_q;
        iss_fire = bus.iss_ready & iss_valid_q;
        rd_fire  = bus.rd_ready & rd_valid_q;
        cap_ok   = 1'b0;
        // A result may only land in a slot whose row has been issued, this cycle included.
        if (bus.res_valid) begin
            if (state_q == StCapture) begin
                cap_ok = 1'b1;
            end else if (state_q == StIssue) begin
                cap_ok = cap_ptr_q < (iss_ptr_q + PW'(iss_fire));
            end
        end
        res_drop = bus.res_valid & ~cap_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StLoad;
            wr_ptr_q    <= '0;
            iss_ptr_q   <= '0;
            cap_ptr_q   <= '0;
            rd_ptr_q    <= '0;
            wr_ready_q  <= 1'b1;
            iss_valid_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (res_drop) begin
                ovf_q <= 1'b1;
            end
            if (cap_ok) begin
                cap_ptr_q <= cap_ptr_q + 1'b1;
            end
            unique case (state_q)
                StLoad: begin
                    if (wr_fire) begin
                        if (wr_ptr_q == LAST) begin
                            wr_ptr_q    <= '0;
                            state_q     <= StIssue;
                            wr_ready_q  <= 1'b0;
                            iss_valid_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (iss_fire) begin
                        if (iss_ptr_q == LAST) begin
                            iss_ptr_q   <= '0;
                            iss_valid_q <= 1'b0;
                            if (cap_ok && cap_ptr_q == LAST) begin
                                cap_ptr_q  <= '0;
                                state_q    <= StDrain;
                                rd_valid_q <= 1'b1;
                            end else begin
                                state_q <= StCapture;
                            end
                        end else begin
                            iss_ptr_q <= iss_ptr_q + 1'b1;
                        end
                    end
                end
                StCapture: begin
                    if (cap_ok && cap_ptr_q == LAST) begin
                        cap_ptr_q  <= '0;
                        state_q    <= StDrain;
                        rd_valid_q <= 1'b1;
                    end
                end
                StDrain: begin
                    if (rd_fire) begin
                        if (rd_ptr_q == LAST) begin
                            rd_ptr_q   <= '0;
                            state_q    <= StLoad;
                            rd_valid_q <= 1'b0;
                            wr_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    ntt_row_bank #(
        .DEPTH (DEPTH),
        .ROW_W (ROW_W)
    ) u_in_bank (
        .clk   (clk),
        .we    (wr_fire & ~rst),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (bus.wr_data),
        .raddr (iss_ptr_q[AW-1:0]),
        .rdata (bus.iss_data)
    );

    ntt_row_bank #(
        .DEPTH (DEPTH),
        .ROW_W (ROW_W)
    ) u_res_bank (
        .clk   (clk),
        .we    (cap_ok & ~rst),
        .waddr (cap_ptr_q[AW-1:0]),
        .wdata (bus.res_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (bus.rd_data)
    );

    assign bus.wr_ready  = wr_ready_q;
    assign bus.iss_valid = iss_valid_q;
    assign bus.rd_valid  = rd_valid_q;
    assign busy          = busy_q;
    assign ovf_err       = ovf_q;

`ifdef NTT_ROW_BUFFER_TWIDDLE_EN
    // Table contents survive rst on purpose; only software writes change them.
    logic [WIDTH-1:0] tw_mem [DEPTH*LANES];
    logic [WIDTH-1:0] tw_rdata_q;

    always_ff @(posedge clk) begin
        if (tw_we) begin
            tw_mem[tw_addr] <= tw_wdata;
        end
        tw_rdata_q <= tw_mem[tw_raddr];
    end

    assign tw_rdata = tw_rdata_q;
`else
    logic unused_tw;
    assign unused_tw = ^{tw_we, tw_addr, tw_wdata, tw_raddr};
    assign tw_rdata  = '0;
`endif

endmodule

// File: tb/tb_ntt_row_buffer.sv
// Self-checking bench for ntt_row_buffer: block-level model plus directed literal checks.
module tb_ntt_row_buffer;
    import ntt_pkg::*;

    localparam int unsigned LANES = 8;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned RW    = LANES * WIDTH;
    localparam logic [RW-1:0] ONES = '1;
    localparam int P_LOAD = 0, P_ISSUE = 1, P_CAP = 2, P_DRAIN = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy, ovf_err, tw_we;
    logic [5:0] tw_addr, tw_raddr;
    logic [7:0] tw_wdata, tw_rdata;

    always #5 clk = ~clk;

    ntt_row_buffer_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

    ntt_row_buffer #(
        .LANES (LANES),
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .ovf_err  (ovf_err),
        .tw_we    (tw_we),
        .tw_addr  (tw_addr),
        .tw_wdata (tw_wdata),
        .tw_raddr (tw_raddr),
        .tw_rdata (tw_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Block-level model: counts of rows loaded/issued/captured/read and the stored rows.
    int            m_phase = P_LOAD;
    int            m_nld = 0, m_niss = 0, m_ncap = 0, m_nrd = 0;
    logic          m_ovf = 1'b0;
    logic [RW-1:0] m_in  [DEPTH];
    logic [RW-1:0] m_res [DEPTH];
    bit            m_wf, m_if, m_rf;
    int            m_issued;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = P_LOAD;
            m_nld = 0; m_niss = 0; m_ncap = 0; m_nrd = 0;
            m_ovf = 1'b0;
        end else begin
            m_wf = (m_phase == P_LOAD) && bus.wr_valid;
            m_if = (m_phase == P_ISSUE) && bus.iss_ready;
            m_rf = (m_phase == P_DRAIN) && bus.rd_ready;
            m_issued = (m_phase == P_CAP) ? DEPTH : m_niss + (m_if ? 1 : 0);
            if (bus.res_valid) begin
                if ((m_phase == P_ISSUE || m_phase == P_CAP) && m_ncap < m_issued) begin
                    m_res[m_ncap] = bus.res_data;
                    m_ncap++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (m_wf) begin
                m_in[m_nld] = bus.wr_data;
                m_nld++;
            end
            if (m_if) m_niss++;
            if (m_rf) m_nrd++;
            case (m_phase)
                P_LOAD:  if (m_nld == DEPTH) begin m_phase = P_ISSUE; m_niss = 0; m_ncap = 0; end
                P_ISSUE: if (m_niss == DEPTH) begin
                    m_phase = (m_ncap == DEPTH) ? P_DRAIN : P_CAP;
                    m_nrd = 0;
                end
                P_CAP:   if (m_ncap == DEPTH) begin m_phase = P_DRAIN; m_nrd = 0; end
                default: if (m_nrd == DEPTH) begin m_phase = P_LOAD; m_nld = 0; end
            endcase
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check1("wr_ready", bus.wr_ready, m_phase == P_LOAD);
            check1("iss_valid", bus.iss_valid, m_phase == P_ISSUE);
            check1("rd_valid", bus.rd_valid, m_phase == P_DRAIN);
            check1("busy", busy, m_phase != P_LOAD);
            check1("ovf_err", ovf_err, m_ovf);
            if (m_phase == P_ISSUE) check("iss_data", bus.iss_data, m_in[m_niss]);
            if (m_phase == P_DRAIN) check("rd_data", bus.rd_data, m_res[m_nrd]);
        end
    end

    // Stimulus knobs; engine mode 1 answers in the issue cycle, mode 2 one cycle later.
    int            cyc = 0;
    int            eng_mode = 0;
    bit            iss_stall = 1'b0, rd_tog = 1'b0, res_pulse = 1'b0, drain_pulse = 1'b0;
    bit            lit_iss = 1'b0, lit_rd = 1'b0;
    bit            pend = 1'b0;
    logic [RW-1:0] pend_d = '0;

    task automatic tick();
        @(negedge clk);
        cyc++;
        bus.iss_ready = iss_stall ? ((cyc % 3) != 0) : 1'b1;
        bus.rd_ready  = rd_tog ? ((cyc % 2) == 1) : 1'b1;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        bus.wr_valid  = 1'b0;
        if (eng_mode == 1 && bus.iss_valid && bus.iss_ready) begin
            bus.res_valid = 1'b1;
            bus.res_data  = bus.iss_data ^ ONES;
        end
        if (eng_mode == 2) begin
            if (pend) begin
                bus.res_valid = 1'b1;
                bus.res_data  = pend_d;
            end
            pend   = bus.iss_valid && bus.iss_ready;
            pend_d = bus.iss_data ^ ONES;
        end
        if (res_pulse || (drain_pulse && bus.rd_valid)) begin
            bus.res_valid = 1'b1;
            bus.res_data  = {LANES{8'hAA}};
            res_pulse     = 1'b0;
            drain_pulse   = 1'b0;
        end
    endtask

    task automatic load_rows(input logic [RW-1:0] base, input logic [RW-1:0] step);
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            bus.wr_valid = 1'b1;
            bus.wr_data  = base + step * RW'(i);
        end
    endtask

    task automatic run_issue(input int limit);
        int k = 0;
        for (int t = 0; t < 200 && k < limit; t++) begin
            tick();
            if (t == 0) check1("busy_after_load", busy, 1'b1);
            if (bus.iss_valid && bus.iss_ready) begin
                if (lit_iss) check("iss_seq", bus.iss_data, {LANES{8'(k + 1)}});
                k++;
            end
        end
        check("iss_count", RW'(k), RW'(limit));
    endtask

    task automatic run_drain();
        int            n = 0;
        bit            stalled = 1'b0;
        logic [RW-1:0] held = '0;
        for (int t = 0; t < 300 && n < DEPTH; t++) begin
            tick();
            if (t == 0 && lit_rd) check1("direct_issue_to_drain", bus.rd_valid, 1'b1);
            if (stalled) check("rd_stall_hold", bus.rd_data, held);
            stalled = 1'b0;
            if (bus.rd_valid) begin
                if (bus.rd_ready) begin
                    if (lit_rd) check("rd_seq", bus.rd_data, {LANES{8'(254 - n)}});
                    n++;
                end else begin
                    stalled = 1'b1;
                    held    = bus.rd_data;
                end
            end
        end
        check("rd_count", RW'(n), RW'(DEPTH));
        tick();
        check1("wr_ready_after_drain", bus.wr_ready, 1'b1);
        check1("rd_valid_after_drain", bus.rd_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.wr_valid = 1'b0; bus.wr_data = '0; bus.iss_ready = 1'b0;
        bus.res_valid = 1'b0; bus.res_data = '0; bus.rd_ready = 1'b0;
        tw_we = 1'b0; tw_addr = '0; tw_wdata = '0; tw_raddr = '0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check1("reset_wr_ready", bus.wr_ready, 1'b1);
        check1("reset_busy", busy, 1'b0);
        check1("reset_iss_valid", bus.iss_valid, 1'b0);
        check1("reset_rd_valid", bus.rd_valid, 1'b0);
        check1("reset_ovf", ovf_err, 1'b0);

        // Rows 0x01..0x08 per lane, engine inverts in the issue cycle.
        eng_mode = 1; lit_iss = 1'b1; lit_rd = 1'b1;
        load_rows({LANES{8'h01}}, {LANES{8'h01}});
        run_issue(DEPTH);
        run_drain();
        lit_iss = 1'b0; lit_rd = 1'b0;

        // Stalled issue/readout, late engine, dropped rows in LOAD and DRAIN.
        eng_mode = 2; iss_stall = 1'b1; rd_tog = 1'b1; res_pulse = 1'b1;
        load_rows(64'h8877665544332211, 64'h0102030405060708);
        check1("ovf_after_load_pulse", ovf_err, 1'b1);
        run_issue(DEPTH);
        drain_pulse = 1'b1;
        run_drain();
        check1("ovf_sticky", ovf_err, 1'b1);

        // Reset in the middle of issuing.
        eng_mode = 1; iss_stall = 1'b0; rd_tog = 1'b0;
        load_rows(64'h0f0e0d0c0b0a0908, 64'h1111111111111111);
        run_issue(3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check1("midrst_wr_ready", bus.wr_ready, 1'b1);
        check1("midrst_iss_valid", bus.iss_valid, 1'b0);
        check1("midrst_ovf", ovf_err, 1'b0);
        check1("midrst_busy", busy, 1'b0);

        // Twiddle table.
        tick();
        tw_we = 1'b1; tw_addr = 6'd10; tw_wdata = 8'h5A;
        tick();
        tw_addr = 6'd63; tw_wdata = 8'hC3; tw_raddr = 6'd10;
        tick();
        tw_we = 1'b0; tw_raddr = 6'd63;
`ifdef NTT_ROW_BUFFER_TWIDDLE_EN
        check("tw_rdata_10", RW'(tw_rdata), RW'(8'h5A));
        tick();
        check("tw_rdata_63", RW'(tw_rdata), RW'(8'hC3));
`else
        check("tw_rdata_10", RW'(tw_rdata), RW'(8'h00));
        tick();
        check("tw_rdata_63", RW'(tw_rdata), RW'(8'h00));
`endif

        // Clean block after reset.
        eng_mode = 1;
        load_rows(64'h5555555555555555, 64'h0123456789abcdef);
        run_issue(DEPTH);
        run_drain();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
